reg_bank_reader: RTL and testbench

- Read-side sequencer for a bank of shared-bus registers. Each register drives a common bus only while its active-low chip select is low, and is high-Z otherwise.
- On Start, the block walks the bank from index 0 to NrOfRegs-1. For each register it asserts that register's chip select, waits a settle time, captures the bus, and then releases the bus.
- Each captured word is offered downstream on a valid/ready handshake. The block is used to dump feature and weight registers to the recognition datapath or the debug UART.

---
 rtl/reg_bank_reader_pkg.sv | 23 ++
 rtl/reg_bank_reader_cs_decoder.sv | 19 +
 rtl/reg_bank_reader.sv | 146 ++++++++++++++
 tb/tb_reg_bank_reader.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_reader_pkg.sv
// Shared definitions for the register-bank read sequencer.
// This package holds the FSM state encoding, the settle-counter width and the
// rule that decides when the sequencer is allowed to advance.
package reg_bank_reader_pkg;

   // State encoding is fixed so that debug dumps and the UART path agree on it.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SELECT = 2'd1,
      ST_OUTPUT = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // The settle counter must be able to count 0..15.
   localparam int CNT_BITS = 4;

   // The sequencer only advances when the clock enable and the tick line are
   // both high.
   function automatic logic step_qualify(input logic clock_enable, input logic tick);
      return clock_enable & tick;
   endfunction

endpackage

// File: rtl/reg_bank_reader_cs_decoder.sv
// Active-low one-hot chip-select decoder for the register bank.
// This block is purely combinational. The parent registers its output, so the
// chip-select lines at the pins never glitch.
module reg_bank_cs_decoder #(
   parameter int NrOfRegs = 4,
   parameter int IdxBits  = 2
) (
   input  logic [IdxBits-1:0]  index,
   input  logic                enable,
   output logic [NrOfRegs-1:0] cs
);

   // When enable is high, exactly one line is low: the one at index.
   // When enable is low, every line is high.
   for (genvar i = 0; i < NrOfRegs; i++) begin : g_cs
      assign cs[i] = ~(enable && (index == IdxBits'(i)));
   end

endmodule

// File: rtl/reg_bank_reader.sv
// Read-side sequencer for a bank of registers that share one bus.
// The block selects each register in turn and holds the select for a settle
// time. It then captures the bus, releases it, and offers the captured word
// downstream on a valid/ready handshake.
module reg_bank_reader
   import reg_bank_reader_pkg::*;
#(
   parameter int NrOfBits     = 8,
   parameter int NrOfRegs     = 4,
   parameter int IdxBits      = 2,
   parameter int SettleCycles = 1
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic                ClockEnable,
   input  logic                Tick,
   input  logic                Start,
   input  logic [NrOfBits-1:0] BusIn,
   output logic [NrOfRegs-1:0] Cs,
   output logic [NrOfBits-1:0] OutData,
   output logic [IdxBits-1:0]  OutIndex,
   output logic                OutValid,
   input  logic                OutReady,
   output logic                Busy,
   output logic                Done
);

   state_t                state, state_nxt;
   logic [IdxBits-1:0]    idx, idx_nxt;
   logic [CNT_BITS-1:0]   cnt, cnt_nxt;
   logic [NrOfBits-1:0]   data_nxt;
   logic [IdxBits-1:0]    oidx_nxt;
   logic                  valid_nxt;
   logic                  done_nxt;
   logic [NrOfRegs-1:0]   cs_nxt;
   logic                  sel_en;
   logic                  step;
   logic                  last;
   logic                  settled;
   logic                  xfer;

   assign step    = step_qualify(ClockEnable, Tick);
   assign last    = (idx == IdxBits'(NrOfRegs - 1));
   assign settled = (cnt >= CNT_BITS'(SettleCycles));
   assign xfer    = step && OutValid && OutReady;
   assign Busy    = (state != ST_IDLE);

   // The chip select follows the next state and next index. As a result, the
   // registered Cs drops on the same edge that enters SELECT, and it rises on
   // the same edge that captures the bus.
   assign sel_en  = (state_nxt == ST_SELECT);

   reg_bank_cs_decoder #(
      .NrOfRegs (NrOfRegs),
      .IdxBits  (IdxBits)
   ) u_cs_decoder (
      .index  (idx_nxt),
      .enable (sel_en),
      .cs     (cs_nxt)
   );

   // State and datapath registers. Reset aborts any scan in progress, and no
   // partial word is emitted.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state    <= ST_IDLE;
         idx      <= '0;
         cnt      <= '0;
         Cs       <= '1;
         OutData  <= '0;
         OutIndex <= '0;
         OutValid <= 1'b0;
         Done     <= 1'b0;
      end else begin
         state    <= state_nxt;
         idx      <= idx_nxt;
         cnt      <= cnt_nxt;
         Cs       <= cs_nxt;
         OutData  <= data_nxt;
         OutIndex <= oidx_nxt;
         OutValid <= valid_nxt;
         Done     <= done_nxt;
      end
   end

   // Next-state and datapath logic. Every register holds its value unless a
   // step lets the scan advance. The only exception is Done, which is a
   // one-clock pulse.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      cnt_nxt   = cnt;
      data_nxt  = OutData;
      oidx_nxt  = OutIndex;
      valid_nxt = OutValid;
      done_nxt  = 1'b0;

      case (state)
         ST_IDLE: begin
            if (step && Start) begin
               idx_nxt   = '0;
               cnt_nxt   = '0;
               state_nxt = ST_SELECT;
            end
         end

         ST_SELECT: begin
            if (step) begin
               if (!settled) begin
                  cnt_nxt = cnt + CNT_BITS'(1);
               end else begin
                  // Capture the bus while the select is still low. The bus
                  // is released on this same edge.
                  data_nxt  = BusIn;
                  oidx_nxt  = idx;
                  valid_nxt = 1'b1;
                  state_nxt = ST_OUTPUT;
               end
            end
         end

         ST_OUTPUT: begin
            if (xfer) begin
               valid_nxt = 1'b0;
               if (last) begin
                  done_nxt  = 1'b1;
                  state_nxt = ST_DONE;
               end else begin
                  idx_nxt   = idx + IdxBits'(1);
                  cnt_nxt   = '0;
                  state_nxt = ST_SELECT;
               end
            end
         end

         ST_DONE: begin
            state_nxt = ST_IDLE;
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_reg_bank_reader.sv
// Self-checking bench for reg_bank_reader.
// Two instances run side by side on the same stimulus:
//   - a 4-register bank with a settle time of 1;
//   - a 1-register bank with a settle time of 0.
// Each instance is checked on every cycle against a model that works from
// step counts.
module tb_reg_bank_reader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, ce, tick, start, ready;
   logic [7:0] bus4, bus1, data4, data1;
   logic [3:0] cs4;
   logic [0:0] cs1;
   logic [1:0] oi4;
   logic [0:0] oi1;
   logic v4, v1, b4, b1, d4, d1;

   logic [7:0] regs [2][4];
   int checks = 0;
   int errors = 0;
   int cycn   = 0;
   bit gate   = 0;

   reg_bank_reader #(.NrOfBits(8), .NrOfRegs(4), .IdxBits(2), .SettleCycles(1)) dut4 (
      .Clock(clk), .Reset(rst), .ClockEnable(ce), .Tick(tick), .Start(start),
      .BusIn(bus4), .Cs(cs4), .OutData(data4), .OutIndex(oi4), .OutValid(v4),
      .OutReady(ready), .Busy(b4), .Done(d4));

   reg_bank_reader #(.NrOfBits(8), .NrOfRegs(1), .IdxBits(1), .SettleCycles(0)) dut1 (
      .Clock(clk), .Reset(rst), .ClockEnable(ce), .Tick(tick), .Start(start),
      .BusIn(bus1), .Cs(cs1), .OutData(data1), .OutIndex(oi1), .OutValid(v1),
      .OutReady(ready), .Busy(b1), .Done(d1));

   // Register models. A register drives the bus only while its select is the
   // single low line. Otherwise the bus floats, which the bench shows as A5.
   always_comb begin
      logic [3:0] m;
      bus4 = 8'hA5;
      for (int i = 0; i < 4; i++) begin
         m = 4'hF;
         m[i] = 1'b0;
         if (cs4 == m) bus4 = regs[0][i];
      end
   end
   assign bus1 = (cs1 == 1'b0) ? regs[1][0] : 8'hA5;

   task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d got %0h expected %0h at %0t", nm, d, act, exp, $time);
      end
   endtask

   // Behavioural model, one per instance. Each instance is in one of four
   // phases:
   //   0 idle, 1 selecting (waiting on steps), 2 word offered, 3 done pulse.
   // The word is offered S+2 steps after a start or a transfer.
   int ph [2];
   int cd [2];
   int midx [2];
   int nrv [2] = '{4, 1};
   int sv  [2] = '{1, 0};

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            ph[d] = 0;
            midx[d] = 0;
         end else begin
            case (ph[d])
               0: if (ce && tick && start) begin
                     midx[d] = 0;
                     cd[d] = sv[d] + 1;
                     ph[d] = 1;
                  end
               1: if (ce && tick) begin
                     cd[d]--;
                     if (cd[d] == 0) ph[d] = 2;
                  end
               2: if (ce && tick && ready) begin
                     if (midx[d] == nrv[d] - 1) begin
                        ph[d] = 3;
                     end else begin
                        midx[d]++;
                        cd[d] = sv[d] + 1;
                        ph[d] = 1;
                     end
                  end
               default: ph[d] = 0;
            endcase
         end
      end
   end

   // Widen both instances' outputs to common shapes so one compare loop
   // serves both.
   logic [3:0] csv [2];
   logic [7:0] dv  [2];
   logic [1:0] iv  [2];
   logic       vv  [2];
   logic       bv  [2];
   logic       dnv [2];

   always_comb begin
      csv[0] = cs4;            csv[1] = {3'b111, cs1};
      dv[0]  = data4;          dv[1]  = data1;
      iv[0]  = oi4;            iv[1]  = {1'b0, oi1};
      vv[0]  = v4;             vv[1]  = v1;
      bv[0]  = b4;             bv[1]  = b1;
      dnv[0] = d4;             dnv[1] = d1;
   end

   // Per-cycle comparison of both instances against the model, plus the
   // bus-exclusivity properties.
   always @(negedge clk) begin
      logic [3:0] e;
      for (int d = 0; d < 2; d++) begin
         e = 4'hF;
         if (ph[d] == 1) e[midx[d]] = 1'b0;
         chk("cs", d, 32'(csv[d]), 32'(e));
         chk("valid", d, 32'(vv[d]), 32'(ph[d] == 2));
         chk("busy", d, 32'(bv[d]), 32'(ph[d] != 0));
         chk("done", d, 32'(dnv[d]), 32'(ph[d] == 3));
         if (ph[d] == 2) begin
            chk("data", d, 32'(dv[d]), 32'(regs[d][midx[d]]));
            chk("index", d, 32'(iv[d]), 32'(midx[d]));
         end
         chk("cs_onehot0", d, 32'($onehot0(~csv[d])), 32'd1);
         if (vv[d]) chk("cs_released", d, 32'(csv[d]), 32'hF);
      end
   end

   // Record the accepted words and count the Done pulses.
   int got4 [$];
   int gi4 [$];
   int got1 [$];
   int ndone4 = 0;
   int ndone1 = 0;

   always @(negedge clk) begin
      if (!rst && ce && tick && ready) begin
         if (v4) begin
            got4.push_back(int'(data4));
            gi4.push_back(int'(oi4));
         end
         if (v1) got1.push_back(int'(data1));
      end
      if (d4) ndone4++;
      if (d1) ndone1++;
   end

   task automatic clear();
      got4.delete();
      gi4.delete();
      got1.delete();
      ndone4 = 0;
      ndone1 = 0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      cycn++;
      tick = gate ? (cycn % 4 == 0) : 1'b1;
   endtask

   task automatic do_start();
      int n = 0;
      while (!tick && n < 10) begin
         cyc();
         n++;
      end
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string nm);
      int n = 0;
      while ((b4 || b1) && n < budget) begin
         cyc();
         n++;
      end
      checks++;
      if (b4 || b1) begin
         errors++;
         $display("FAIL %s timeout busy4=%0b busy1=%0b", nm, b4, b1);
      end
   endtask

   task automatic chk_scan(input string nm);
      chk({nm, "_n4"}, 0, 32'(got4.size()), 32'd4);
      if (got4.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            chk({nm, "_w4"}, 0, 32'(got4[i]), 32'((i + 1) * 8'h11));
            chk({nm, "_i4"}, 0, 32'(gi4[i]), 32'(i));
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      int l4;
      int l1;

      rst = 1'b1;
      ce = 1'b1;
      tick = 1'b1;
      start = 1'b0;
      ready = 1'b1;
      for (int i = 0; i < 4; i++) regs[0][i] = 8'((i + 1) * 8'h11);
      for (int i = 0; i < 4; i++) regs[1][i] = 8'h5A;

      // Reset state.
      repeat (3) cyc();
      chk("rst_cs4", 0, 32'(cs4), 32'hF);
      chk("rst_cs1", 1, 32'(cs1), 32'h1);
      chk("rst_data", 0, 32'(data4), 32'h0);
      chk("rst_idx", 0, 32'(oi4), 32'h0);
      chk("rst_valid", 0, 32'(v4), 32'h0);
      chk("rst_busy", 0, 32'(b4), 32'h0);
      chk("rst_done", 0, 32'(d4), 32'h0);
      rst = 1'b0;
      cyc();

      // Basic scan, with the latency measured from the start step.
      clear();
      start = 1'b1;
      cyc();
      start = 1'b0;
      l4 = 0;
      l1 = 0;
      for (n = 1; n < 20; n++) begin
         if (v4 && l4 == 0) l4 = n;
         if (v1 && l1 == 0) l1 = n;
         if (l4 != 0 && l1 != 0) break;
         cyc();
      end
      chk("lat4", 0, 32'(l4), 32'd3);
      chk("lat1", 1, 32'(l1), 32'd2);
      wait_idle(100, "basic");
      chk_scan("basic");
      chk("basic_done4", 0, 32'(ndone4), 32'd1);
      chk("basic_n1", 1, 32'(got1.size()), 32'd1);
      if (got1.size() > 0) chk("basic_w1", 1, 32'(got1[0]), 32'h5A);
      chk("basic_done1", 1, 32'(ndone1), 32'd1);

      // Backpressure on word 2.
      clear();
      do_start();
      n = 0;
      while (!(v4 && oi4 == 2'd2) && n < 50) begin
         cyc();
         n++;
      end
      ready = 1'b0;
      for (int k = 0; k < 10; k++) begin
         cyc();
         chk("bp_valid", 0, 32'(v4), 32'd1);
         chk("bp_data", 0, 32'(data4), 32'h33);
         chk("bp_idx", 0, 32'(oi4), 32'd2);
         chk("bp_cs", 0, 32'(cs4), 32'hF);
      end
      ready = 1'b1;
      wait_idle(100, "bp");
      chk_scan("bp");

      // Tick gating. A Start on a non-tick cycle must be ignored.
      gate = 1;
      clear();
      n = 0;
      while (tick && n < 8) begin
         cyc();
         n++;
      end
      start = 1'b1;
      cyc();
      start = 1'b0;
      chk("tick_ign4", 0, 32'(b4), 32'd0);
      chk("tick_ign1", 1, 32'(b1), 32'd0);
      do_start();
      wait_idle(400, "tick");
      chk_scan("tick");
      gate = 0;
      cyc();

      // Reset in mid-scan, while register 1 is selected.
      clear();
      do_start();
      n = 0;
      while (cs4 != 4'b1101 && n < 50) begin
         cyc();
         n++;
      end
      chk("mid_seen", 0, 32'(cs4), 32'hD);
      rst = 1'b1;
      cyc();
      chk("mid_cs", 0, 32'(cs4), 32'hF);
      chk("mid_valid", 0, 32'(v4), 32'd0);
      chk("mid_busy", 0, 32'(b4), 32'd0);
      chk("mid_done", 0, 32'(d4), 32'd0);
      rst = 1'b0;
      cyc();
      clear();
      do_start();
      wait_idle(100, "mid");
      chk_scan("mid");

      // Repeated Start pulses while the 4-register scan is busy.
      clear();
      do_start();
      n = 0;
      while (b4 && n < 200) begin
         start = (n % 3 == 0);
         cyc();
         n++;
      end
      start = 1'b0;
      wait_idle(100, "busy_start");
      chk_scan("busy_start");
      chk("busy_done4", 0, 32'(ndone4), 32'd1);

      // Randomised traffic. The model checks every cycle.
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk);
         #1;
         ce    = ($urandom_range(0, 3) != 0);
         tick  = ($urandom_range(0, 1) != 0);
         ready = ($urandom_range(0, 2) != 0);
         start = ($urandom_range(0, 7) == 0);
         rst   = ($urandom_range(0, 299) == 0);
         if (!b4 && !b1) begin
            for (int i = 0; i < 4; i++) regs[0][i] = 8'($urandom);
            regs[1][0] = 8'($urandom);
         end
      end
      rst = 1'b0;
      ce = 1'b1;
      tick = 1'b1;
      ready = 1'b1;
      start = 1'b0;
      wait_idle(200, "random_drain");
      cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
